// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module  : input_debouncer_if
// Brief   : Raw inputs and conditioned level/edge outputs of input_debouncer.
// Revision: 1.0 - initial release
// ============================================================================
interface input_debouncer_if #(
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0] Input;
    logic [NUM_CHANNELS-1:0] Level;
    logic [NUM_CHANNELS-1:0] Rise;
    logic [NUM_CHANNELS-1:0] Fall;
    logic                    Changed;

    modport master (output Input, input Level, Rise, Fall, Changed);
    modport slave  (input Input, output Level, Rise, Fall, Changed);
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : input_debouncer
// Brief   : Per-channel synchronizer plus tick-qualified debounce FSM with a
//           shared prescaler; emits clean levels and one-cycle edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_STAGES   = 2,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 8,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    input_debouncer_if.slave   bus
);

    localparam int C_PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int C_CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [C_PS_W-1:0]  C_PS_LAST  = C_PS_W'(PRESCALE - 1);
    localparam logic [C_PS_W-1:0]  C_PS_ONE   = C_PS_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STABLE_TICKS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_STABLE    = 1'b0,
        ST_CANDIDATE = 1'b1
    } state_t;

    logic [C_PS_W-1:0]       r_pre_q;
    logic [C_PS_W-1:0]       w_pre_d;
    logic                    w_tick;
    logic [NUM_CHANNELS-1:0] w_level_vec;
    logic [NUM_CHANNELS-1:0] w_rise_vec;
    logic [NUM_CHANNELS-1:0] w_fall_vec;

    always_comb begin
        w_tick  = (r_pre_q == C_PS_LAST);
        w_pre_d = w_tick ? '0 : (r_pre_q + C_PS_ONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pre_q <= '0;
        end else begin
            r_pre_q <= w_pre_d;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        logic [NUM_STAGES-1:0] r_sync_q;
        logic [NUM_STAGES-1:0] w_sync_d;
        logic                  w_sync;
        state_t                r_state_q;
        state_t                w_state_d;
        logic [C_CNT_W-1:0]    r_cnt_q;
        logic [C_CNT_W-1:0]    w_cnt_d;
        logic                  r_level_q;
        logic                  w_level_d;
        logic                  r_rise_q;
        logic                  w_rise_d;
        logic                  r_fall_q;
        logic                  w_fall_d;

        always_comb begin
            w_sync_d  = {r_sync_q[NUM_STAGES-2:0], bus.Input[i]};
            w_sync    = r_sync_q[NUM_STAGES-1];
            w_state_d = r_state_q;
            w_cnt_d   = r_cnt_q;
            w_level_d = r_level_q;
            w_rise_d  = 1'b0;
            w_fall_d  = 1'b0;
            case (r_state_q)
                ST_STABLE: begin
                    w_cnt_d = '0;
                    if (w_sync != r_level_q) begin
                        w_state_d = ST_CANDIDATE;
                    end
                end
                ST_CANDIDATE: begin
                    // A reversal abandons qualification even on a tick cycle.
                    if (w_sync == r_level_q) begin
                        w_state_d = ST_STABLE;
                        w_cnt_d   = '0;
                    end else if (w_tick) begin
                        if (r_cnt_q == C_CNT_LAST) begin
                            w_level_d = ~r_level_q;
                            w_rise_d  = ~r_level_q;
                            w_fall_d  = r_level_q;
                            w_state_d = ST_STABLE;
                            w_cnt_d   = '0;
                        end else begin
                            w_cnt_d = r_cnt_q + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_STABLE;
                    w_cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_sync_q  <= {NUM_STAGES{RESET_LEVEL}};
                r_state_q <= ST_STABLE;
                r_cnt_q   <= '0;
                r_level_q <= RESET_LEVEL;
                r_rise_q  <= 1'b0;
                r_fall_q  <= 1'b0;
            end else begin
                r_sync_q  <= w_sync_d;
                r_state_q <= w_state_d;
                r_cnt_q   <= w_cnt_d;
                r_level_q <= w_level_d;
                r_rise_q  <= w_rise_d;
                r_fall_q  <= w_fall_d;
            end
        end

        assign w_level_vec[i] = r_level_q;
        assign w_rise_vec[i]  = r_rise_q;
        assign w_fall_vec[i]  = r_fall_q;
    end

    assign bus.Level   = w_level_vec;
    assign bus.Rise    = w_rise_vec;
    assign bus.Fall    = w_fall_vec;
    assign bus.Changed = |(w_rise_vec | w_fall_vec);

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_debouncer
// Brief   : Directed bench for input_debouncer (main and degenerate configs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   n_fail;

    input_debouncer_if #(.NUM_CHANNELS(4)) bus  ();
    input_debouncer_if #(.NUM_CHANNELS(4)) bus1 ();

    input_debouncer #(
        .NUM_CHANNELS (4),
        .NUM_STAGES   (2),
        .PRESCALE     (4),
        .STABLE_TICKS (3),
        .RESET_LEVEL  (1'b0)
    ) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    input_debouncer #(
        .NUM_CHANNELS (4),
        .NUM_STAGES   (2),
        .PRESCALE     (1),
        .STABLE_TICKS (1),
        .RESET_LEVEL  (1'b0)
    ) u_dut_min (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rise_cnt;
        int rise_edge;
        int bad;
        int f2_cnt;
        int f3_cnt;
        int f2_edge;
        int f3_edge;
        int chg_cnt;

        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        bus.Input  = 4'b1111;
        bus1.Input = 4'b0000;

        // Reset held three cycles with all inputs high
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_outputs", {bus.Level, bus.Rise, bus.Fall, bus.Changed}, 32'h0);
        end
        rst       = 1'b0;
        bus.Input = 4'b0000;
        step();
        check("post_reset_outputs", {bus.Level, bus.Rise, bus.Fall, bus.Changed}, 32'h0);
        repeat (5) step();

        // Clean rise on channel 0
        rise_cnt  = 0;
        rise_edge = -1;
        bad       = 0;
        bus.Input = 4'b0001;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus.Rise[0]) begin
                rise_cnt++;
                rise_edge = e;
            end
            if (bus.Rise[3:1] != 3'b000 || bus.Fall != 4'b0000 || bus.Level[3:1] != 3'b000) bad++;
        end
        check("rise_pulse_count", rise_cnt, 1);
        check("rise_edge_window", (rise_edge >= 12 && rise_edge <= 15), 1);
        check("rise_level", bus.Level, 4'b0001);
        check("rise_others_quiet", bad, 0);

        // Bounce rejection on channel 1
        bad = 0;
        for (int p = 0; p < 4; p++) begin
            bus.Input[1] = (p % 2 == 0);
            repeat (5) begin
                step();
                if (bus.Level[1] || bus.Rise[1] || bus.Fall[1]) bad++;
            end
        end
        repeat (20) begin
            step();
            if (bus.Level[1] || bus.Rise[1] || bus.Fall[1]) bad++;
        end
        check("bounce_no_activity", bad, 0);
        check("bounce_level", bus.Level, 4'b0001);

        // Simultaneous falls on channels 2 and 3
        bus.Input = 4'b1111;
        repeat (25) step();
        check("all_high_level", bus.Level, 4'b1111);
        f2_cnt  = 0;
        f3_cnt  = 0;
        f2_edge = -1;
        f3_edge = -2;
        chg_cnt = 0;
        bad     = 0;
        bus.Input = 4'b0011;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus.Fall[2]) begin f2_cnt++; f2_edge = e; end
            if (bus.Fall[3]) begin f3_cnt++; f3_edge = e; end
            if (bus.Changed) chg_cnt++;
            if (bus.Rise != 4'b0000 || bus.Fall[1:0] != 2'b00) bad++;
        end
        check("fall2_count", f2_cnt, 1);
        check("fall3_count", f3_cnt, 1);
        check("fall_same_edge", f2_edge, f3_edge);
        check("fall_edge_window", (f2_edge >= 12 && f2_edge <= 15), 1);
        check("fall_changed_count", chg_cnt, 1);
        check("fall_others_quiet", bad, 0);
        check("fall_level", bus.Level, 4'b0011);

        // Reset while channel 0 is qualifying with Cnt=2
        bus.Input = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.Input = 4'b0001;
        check("midrst_pre_clear", bus.Level, 4'b0000);
        bad = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (bus.Rise != 4'b0000 || bus.Fall != 4'b0000 || bus.Level != 4'b0000) bad++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_outputs", {bus.Level, bus.Rise, bus.Fall, bus.Changed}, 32'h0);
        check("midrst_no_early_pulse", bad, 0);
        rise_cnt  = 0;
        rise_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus.Rise[0]) begin
                rise_cnt++;
                rise_edge = e;
            end
        end
        check("midrst_rise_count", rise_cnt, 1);
        check("midrst_rise_window", (rise_edge >= 12 && rise_edge <= 15), 1);
        check("midrst_level", bus.Level, 4'b0001);

        // Degenerate configuration: PRESCALE=1, STABLE_TICKS=1
        check("min_idle_level", bus1.Level, 4'b0000);
        bus1.Input = 4'b0001;
        bad = 0;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (bus1.Level != 4'b0000 || bus1.Rise != 4'b0000) bad++;
        end
        check("min_no_early_change", bad, 0);
        step();
        check("min_level_edge4", bus1.Level, 4'b0001);
        check("min_rise_edge4", bus1.Rise, 4'b0001);
        check("min_changed_edge4", bus1.Changed, 1'b1);
        step();
        check("min_rise_cleared", bus1.Rise, 4'b0000);
        check("min_level_held", bus1.Level, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
